// File: rtl/dcache_pkg.sv
// Shared definitions for the write-through data cache: access sizes, FSM states,
// geometry helpers and byte-lane mask/placement functions.
package dcache_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_B    = 2'b01;
  localparam logic [1:0] SZ_H    = 2'b10;
  localparam logic [1:0] SZ_W    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_WRITE,
    ST_RESP
  } state_t;

  function automatic int unsigned index_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned lines);
    return addr_w - 2 - $clog2(lines);
  endfunction

  // Byte-lane enable; address bits below the access size are ignored.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its bytes.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_B:    lane_data = {4{wdata[7:0]}};
      SZ_H:    lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/data/valid storage for the direct-mapped cache: combinational read,
// refill write port, per-byte-lane store merge and flush-all.
module dcache_array #(
  parameter int unsigned LINES   = 64,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [31:0]        rd_data_o,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic               refill_we_i,
  input  logic [TAG_W-1:0]   refill_tag_i,
  input  logic [31:0]        refill_data_i,
  input  logic [3:0]         lane_we_i,
  input  logic [31:0]        lane_data_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  always_ff @(posedge clk) begin
    if (rst || flush_i) valid_q <= '0;
    else if (refill_we_i) valid_q[wr_idx_i] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (refill_we_i) begin
      tag_q[wr_idx_i]  <= refill_tag_i;
      data_q[wr_idx_i] <= refill_data_i;
    end else begin
      for (int unsigned i = 0; i < 4; i++)
        if (lane_we_i[i]) data_q[wr_idx_i][8*i +: 8] <= lane_data_i[8*i +: 8];
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a
// refill/write FSM, req/ack handshakes, full flush and hit/miss counters.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINES  = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [1:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  output logic [31:0]       rdata_o,
  output logic              ready_o,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [1:0]        mem_size_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int unsigned INDEX_W = index_w(LINES);
  localparam int unsigned TAG_W   = tag_w(ADDR_W, LINES);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, resp_q;
  logic [1:0]        size_q;
  logic              wr_q, flush_pend_q;
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

  logic [ADDR_W-1:0] cur_addr;
  logic [TAG_W-1:0]  cur_tag, rd_tag;
  logic [31:0]       rd_data;
  logic              rd_valid, hit, req_go, ld_hit, ld_miss, flush_all;

  // Request fields are captured on acceptance so an in-flight transaction
  // completes unchanged even if the CPU drops req_i.
  assign cur_addr = (state_q == ST_IDLE) ? addr_i : addr_q;
  assign cur_tag  = cur_addr[ADDR_W-1 -: TAG_W];
  assign hit      = rd_valid && (rd_tag == cur_tag);
  assign req_go   = (state_q == ST_IDLE) && req_i && (size_i != SZ_NONE);
  assign ld_hit   = req_go && !wr_i && hit;
  assign ld_miss  = req_go && !wr_i && !hit;
  assign flush_all = ((state_q == ST_IDLE) && flush_i) ||
                     ((state_q == ST_RESP) && (flush_pend_q || flush_i));

  dcache_array #(.LINES(LINES), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_all),
    .rd_idx_i     (cur_addr[2 +: INDEX_W]),
    .rd_valid_o   (rd_valid),
    .rd_tag_o     (rd_tag),
    .rd_data_o    (rd_data),
    .wr_idx_i     (addr_q[2 +: INDEX_W]),
    .refill_we_i  ((state_q == ST_REFILL) && mem_ack_i),
    .refill_tag_i (addr_q[ADDR_W-1 -: TAG_W]),
    .refill_data_i(mem_rdata_i),
    .lane_we_i    (((state_q == ST_WRITE) && mem_ack_i && hit) ? byte_en(size_q, addr_q[1:0]) : 4'b0000),
    .lane_data_i  (lane_data(size_q, wdata_q))
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_go) state_d = wr_i ? ST_WRITE : (hit ? ST_IDLE : ST_REFILL);
      ST_REFILL,
      ST_WRITE:  if (mem_ack_i) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o     = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_wr_o    = 1'b0;
    mem_size_o  = SZ_NONE;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      ST_IDLE: if (ld_hit) begin
        ready_o = 1'b1;
        rdata_o = rd_data;
      end
      ST_REFILL: begin
        mem_req_o  = 1'b1;
        mem_size_o = SZ_W;
        mem_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
      end
      ST_WRITE: begin
        mem_req_o   = 1'b1;
        mem_wr_o    = 1'b1;
        mem_size_o  = size_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
      end
      ST_RESP: begin
        ready_o = 1'b1;
        rdata_o = wr_q ? rd_data : resp_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= SZ_NONE;
      wr_q         <= 1'b0;
      resp_q       <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (req_go) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        size_q  <= size_i;
        wr_q    <= wr_i;
      end
      if (ld_hit)  hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (ld_miss) miss_cnt_q <= miss_cnt_q + 1'b1;
      if ((state_q == ST_REFILL) && mem_ack_i) resp_q <= mem_rdata_i;
      if (state_q == ST_RESP) flush_pend_q <= 1'b0;
      else if (flush_i && (state_q != ST_IDLE)) flush_pend_q <= 1'b1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized self-checking bench for dcache_wt: a backing-store memory plus a
// valid/tag shadow of the cache; every load must return the memory word.
module tb_dcache_wt;
  import dcache_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned NL = 8;
  localparam int unsigned CW = 4;

  logic          clk, rst, req_i, wr_i, flush_i, ready_o;
  logic [1:0]    size_i, mem_size_o;
  logic [AW-1:0] addr_i, mem_addr_o;
  logic [31:0]   wdata_i, rdata_o, mem_wdata_o, mem_rdata_i;
  logic          mem_req_o, mem_wr_o, mem_ack_i;
  logic [CW-1:0] hit_cnt_o, miss_cnt_o;

  dcache_wt #(.ADDR_W(AW), .LINES(NL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .wr_i(wr_i), .size_i(size_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i), .rdata_o(rdata_o),
    .ready_o(ready_o), .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o),
    .mem_size_o(mem_size_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks, n_fail;
  logic [31:0] mem [int unsigned];
  bit          m_valid [NL];
  int unsigned m_tag [NL];
  int unsigned m_hits, m_misses;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int unsigned a);
    int unsigned wa = a & ~32'd3;
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E3779B9) ^ 32'hC3A51F07;
  endfunction

  function automatic bit m_hit(input int unsigned a);
    return m_valid[(a / 4) % NL] && (m_tag[(a / 4) % NL] == a / (4 * NL));
  endfunction

  task automatic mem_write(input int unsigned a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    int unsigned base, n;
    w    = mem_rd(a);
    n    = (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
    base = (a % 4) & ~(n - 1);
    for (int unsigned k = 0; k < n; k++) w[8*(base+k) +: 8] = wd[8*k +: 8];
    mem[a & ~32'd3] = w;
  endtask

  task automatic m_flush();
    for (int unsigned i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_cnts();
    check_eq("hit_cnt", 32'(hit_cnt_o), m_hits % (1 << CW));
    check_eq("miss_cnt", 32'(miss_cnt_o), m_misses % (1 << CW));
  endtask

  // Starts and ends on a negedge. fmode: 1 = flush with a load hit, 2 = flush while waiting on memory.
  task automatic access(input bit wr, input logic [1:0] sz, input int unsigned a,
                        input logic [31:0] wd, input int unsigned dly, input int unsigned fmode,
                        output logic [31:0] got);
    bit h;
    h = m_hit(a);
    req_i = 1'b1; wr_i = wr; size_i = sz; addr_i = a; wdata_i = wd;
    flush_i = (fmode == 1) && !wr && h;
    #1;
    if (!wr && h) begin
      check_eq("hit_ready", 32'(ready_o), 1);
      check_eq("hit_rdata", rdata_o, mem_rd(a));
      got = rdata_o;
      @(posedge clk);
      m_hits++;
      if (flush_i) m_flush();
      @(negedge clk);
      flush_i = 1'b0;
    end else begin
      check_eq("miss_ready", 32'(ready_o), 0);
      if (!wr) m_misses++;
      @(negedge clk);
      flush_i = (fmode == 2);
      check_eq("mem_req", 32'(mem_req_o), 1);
      check_eq("mem_wr", 32'(mem_wr_o), 32'(wr));
      check_eq("mem_size", 32'(mem_size_o), wr ? 32'(sz) : 32'(SZ_W));
      check_eq("mem_addr", mem_addr_o, wr ? a : (a & ~32'd3));
      if (wr) check_eq("mem_wdata", mem_wdata_o, wd);
      repeat (dly) begin
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("wait_req", 32'(mem_req_o), 1);
        check_eq("wait_ready", 32'(ready_o), 0);
      end
      mem_ack_i = 1'b1;
      mem_rdata_i = mem_rd(a);
      @(posedge clk);
      if (wr) mem_write(a, sz, wd);
      else begin
        m_valid[(a / 4) % NL] = 1'b1;
        m_tag[(a / 4) % NL]   = a / (4 * NL);
      end
      @(negedge clk);
      mem_ack_i = 1'b0; flush_i = 1'b0; mem_rdata_i = $urandom;
      check_eq("resp_ready", 32'(ready_o), 1);
      check_eq("resp_mem_req", 32'(mem_req_o), 0);
      if (!wr) check_eq("resp_rdata", rdata_o, mem_rd(a));
      got = rdata_o;
      @(posedge clk);
      if (fmode == 2) m_flush();
      @(negedge clk);
    end
    check_cnts();
  endtask

  logic [31:0] got;

  initial begin
    n_checks = 0; n_fail = 0; m_hits = 0; m_misses = 0;
    m_flush();
    rst = 1'b1; req_i = 1'b0; wr_i = 1'b0; size_i = SZ_NONE; addr_i = '0;
    wdata_i = '0; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(ready_o), 0);
    check_eq("rst_mem_req", 32'(mem_req_o), 0);
    check_eq("rst_mem_bus", {mem_wr_o, mem_size_o, 29'd0} | mem_addr_o | mem_wdata_o, 0);
    check_eq("rst_rdata", rdata_o, 0);
    check_cnts();
    rst = 1'b0;

    mem[32'h1000] = 32'hDEADBEEF;
    access(0, SZ_W, 32'h1000, 0, 1, 0, got);
    check_eq("tp_refill_data", got, 32'hDEADBEEF);
    check_eq("tp_miss1", 32'(miss_cnt_o), 1);
    access(0, SZ_W, 32'h1000, 0, 0, 0, got);
    check_eq("tp_hit1", 32'(hit_cnt_o), 1);
    access(1, SZ_B, 32'h1002, 32'h000000AA, 0, 0, got);
    access(0, SZ_W, 32'h1000, 0, 0, 0, got);
    check_eq("tp_merge", got, 32'hDEAABEEF);
    access(1, SZ_W, 32'h2000, 32'h12345678, 2, 0, got);
    access(0, SZ_W, 32'h2000, 0, 0, 0, got);
    check_eq("tp_nwa_data", got, 32'h12345678);
    access(0, SZ_W, 32'h1000, 0, 0, 0, got);
    access(0, SZ_W, 32'h1000 + 4 * NL, 0, 1, 0, got);
    access(0, SZ_W, 32'h1000, 0, 0, 0, got);
    access(0, SZ_W, 32'h1044, 0, 2, 2, got);
    access(0, SZ_W, 32'h1000, 0, 0, 0, got);
    access(0, SZ_W, 32'h1000, 0, 0, 1, got);
    access(0, SZ_W, 32'h1000, 0, 0, 0, got);

    // Reset while a refill is outstanding.
    req_i = 1'b1; wr_i = 1'b0; size_i = SZ_W; addr_i = 32'h3000;
    @(negedge clk);
    check_eq("rst_mid_req_before", 32'(mem_req_o), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_i = 1'b0;
    m_flush(); m_hits = 0; m_misses = 0;
    check_eq("rst_mid_req_after", 32'(mem_req_o), 0);
    check_cnts();

    for (int unsigned it = 0; it < 400; it++) begin
      int unsigned op, a;
      op = $urandom_range(0, 11);
      a  = 32'h1000 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, NL - 1) << 2) + $urandom_range(0, 3);
      if (op < 6)
        access(0, 2'($urandom_range(1, 3)), a, 0, $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0, got);
      else if (op < 9)
        access(1, 2'($urandom_range(1, 3)), a, $urandom, $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0) ? 2 : 0, got);
      else if (op == 9) begin
        req_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        m_flush();
      end else if (op == 10) begin
        req_i = 1'b1; wr_i = 1'($urandom); size_i = SZ_NONE; addr_i = a;
        #1;
        check_eq("none_ready", 32'(ready_o), 0);
        @(negedge clk);
        check_eq("none_mem_req", 32'(mem_req_o), 0);
        req_i = 1'b0;
      end else begin
        req_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    req_i = 1'b0;
    @(negedge clk);
    check_cnts();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
